// File: rtl/led_chase_engine.sv
// led_chase_engine: steps a 16-LED chase pattern on each tick pulse.
// Four modes (rotate left/right, bounce, fill), a stop button that
// toggles pause through a synchroniser, and a wrap pulse per period.
module led_chase_engine #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     stop,
    input  logic [1:0]               mode,
    output logic [WIDTH-1:0]         led,
    output logic [$clog2(WIDTH):0]   position,
    output logic                     dir,
    output logic                     paused,
    output logic                     wrap
);

    localparam int PW = $clog2(WIDTH) + 1;
    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);
    localparam logic [PW-1:0] FULL = PW'(WIDTH);

    typedef enum logic [1:0] {
        MODE_ROT_LEFT  = 2'b00,
        MODE_ROT_RIGHT = 2'b01,
        MODE_BOUNCE    = 2'b10,
        MODE_FILL      = 2'b11
    } mode_e;

    logic [SYNC_STAGES-1:0] stop_sync;
    logic                   stop_prev;
    logic                   stop_edge;
    logic                   step;

    mode_e                  mode_q;
    mode_e                  mode_d;
    logic [PW-1:0]          pos_d;
    logic [PW-1:0]          pos_inc;
    logic [PW-1:0]          pos_dec;
    logic                   dir_d;
    logic                   wrap_d;
    logic                   paused_d;
    logic [WIDTH-1:0]       led_d;

    // Bring the raw button into the clock domain and remember the last synced level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stop_sync <= '0;
            stop_prev <= 1'b0;
        end else begin
            stop_sync <= {stop_sync[SYNC_STAGES-2:0], stop};
            stop_prev <= stop_sync[SYNC_STAGES-1];
        end
    end

    assign stop_edge = stop_sync[SYNC_STAGES-1] & ~stop_prev;
    assign step      = tick & ~paused & ~stop_edge;
    assign pos_inc   = position + PW'(1);
    assign pos_dec   = position - PW'(1);

    // Next pattern state: a mode change on a step loads the start state, otherwise advance
    always_comb begin
        mode_d   = mode_q;
        pos_d    = position;
        dir_d    = dir;
        wrap_d   = 1'b0;
        paused_d = paused ^ stop_edge;
        led_d    = led;

        if (step) begin
            if (mode_e'(mode) != mode_q) begin
                mode_d = mode_e'(mode);
                case (mode_e'(mode))
                    MODE_ROT_RIGHT: begin
                        pos_d = LAST;
                        dir_d = 1'b1;
                    end
                    default: begin
                        pos_d = '0;
                        dir_d = 1'b0;
                    end
                endcase
            end else begin
                case (mode_q)
                    MODE_ROT_LEFT: begin
                        if (position == LAST) begin
                            pos_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            pos_d = pos_inc;
                        end
                    end
                    MODE_ROT_RIGHT: begin
                        if (position == '0) begin
                            pos_d  = LAST;
                            wrap_d = 1'b1;
                        end else begin
                            pos_d = pos_dec;
                        end
                    end
                    MODE_BOUNCE: begin
                        if (!dir) begin
                            pos_d = pos_inc;
                            if (pos_inc == LAST) begin
                                dir_d = 1'b1;
                            end
                        end else begin
                            pos_d = pos_dec;
                            if (pos_dec == '0) begin
                                dir_d  = 1'b0;
                                wrap_d = 1'b1;
                            end
                        end
                    end
                    MODE_FILL: begin
                        if (!dir) begin
                            pos_d = pos_inc;
                            if (pos_inc == FULL) begin
                                dir_d = 1'b1;
                            end
                        end else begin
                            pos_d = pos_dec;
                            if (pos_dec == '0) begin
                                dir_d  = 1'b0;
                                wrap_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        pos_d = position;
                    end
                endcase
            end

            if (mode_d == MODE_FILL) begin
                led_d = ~({WIDTH{1'b1}} << pos_d);
            end else begin
                led_d = {{(WIDTH-1){1'b0}}, 1'b1} << pos_d;
            end
        end
    end

    // Register every output so the LEDs and 7-seg path see glitch-free values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= MODE_ROT_LEFT;
            led      <= {{(WIDTH-1){1'b0}}, 1'b1};
            position <= '0;
            dir      <= 1'b0;
            paused   <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            led      <= led_d;
            position <= pos_d;
            dir      <= dir_d;
            paused   <= paused_d;
            wrap     <= wrap_d;
        end
    end

endmodule
